reg_dump_sequencer: RTL and testbench

- Debug-unit controller for the register bank's asynchronous read port (`addrAsync`/`outputAsync`).
- On a dump request it halts the pipeline and waits for the halt acknowledge.
- It then walks every register address in order, serializes each 32-bit word into bytes, and streams them to the UART transmitter over a valid/ready handshake.
- On completion it releases the halt.
- Sits between the debug unit, the pipeline stall logic, the register bank and the UART TX.

---
 rtl/debug_pkg.sv | 18 +
 rtl/word_serializer.sv | 39 +++
 rtl/reg_dump_sequencer.sv | 113 +++++++++++
 tb/tb_reg_dump_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the debug unit's register dump path.
// State codes stay plain logic constants so legacy tools can read them.
package debug_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int BYTES_PER_WORD = DEF_DATA_W / 8;
   localparam logic [7:0] DEF_HEADER_BYTE = 8'hA5;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_WAIT_ACK = 3'd1;
   localparam state_t S_HDR = 3'd2;
   localparam state_t S_LOAD = 3'd3;
   localparam state_t S_SEND = 3'd4;
   localparam state_t S_DONE = 3'd5;

endpackage

// File: rtl/word_serializer.sv
// Big-endian byte serializer for one register word.
// The parent owns the handshake and only pulses load/advance.
module word_serializer
   import debug_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [DATA_W-1:0] data,
   output logic [7:0]        data_byte,
   output logic              last
);

   localparam int BYTES = DATA_W / 8;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= data;
         cnt   <= '0;
      end else if (advance) begin
         shreg <= shreg << 8;
         cnt   <= cnt + 1'b1;
      end
   end

   assign data_byte = shreg[DATA_W-1 -: 8];
   assign last      = (cnt == CNT_W'(BYTES - 1));

endmodule

// File: rtl/reg_dump_sequencer.sv
// Halts the pipeline, walks the register bank and streams a
// header byte plus every register, MSB first, to the UART TX.
module reg_dump_sequencer
   import debug_pkg::*;
#(
   parameter int         NUM_REGS    = 32,
   parameter int         ADDR_W      = 5,
   parameter int         DATA_W      = DEF_DATA_W,
   parameter logic [7:0] HEADER_BYTE = DEF_HEADER_BYTE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dump_req,
   input  logic              halt_ack,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              tx_ready,
   output logic              halt,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_t     state;
   state_t     nxt;
   logic       ser_load;
   logic       ser_adv;
   logic       ser_last;
   logic [7:0] ser_byte;
   logic       word_end;
   logic       last_reg;

   assign last_reg = (reg_addr == LAST_ADDR);
   assign word_end = (state == S_SEND) && tx_ready && ser_last;
   assign ser_load = (state == S_LOAD);
   assign ser_adv  = (state == S_SEND) && tx_ready && !ser_last;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (dump_req) nxt = S_WAIT_ACK;
         S_WAIT_ACK: if (halt_ack) nxt = S_HDR;
         S_HDR:      if (tx_ready) nxt = S_LOAD;
         S_LOAD:     nxt = S_SEND;
         S_SEND:     if (word_end) nxt = last_reg ? S_DONE : S_LOAD;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Address only moves on whole-word boundaries; it never wraps by overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_addr <= '0;
      end else if ((state == S_HDR) && tx_ready) begin
         reg_addr <= '0;
      end else if (word_end && !last_reg) begin
         reg_addr <= reg_addr + 1'b1;
      end else if (state == S_DONE) begin
         reg_addr <= '0;
      end
   end

   word_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clock     (clock),
      .reset     (reset),
      .load      (ser_load),
      .advance   (ser_adv),
      .data      (reg_data),
      .data_byte (ser_byte),
      .last      (ser_last)
   );

   // Outputs decode the registered state, so reset clears them at once.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      halt      = 1'b0;
      dump_done = 1'b0;
      unique case (1'b1)
         (state == S_HDR): begin
            tx_valid = 1'b1;
            tx_data  = HEADER_BYTE;
            halt     = 1'b1;
         end
         (state == S_SEND): begin
            tx_valid = 1'b1;
            tx_data  = ser_byte;
            halt     = 1'b1;
         end
         (state == S_WAIT_ACK),
         (state == S_LOAD): halt = 1'b1;
         (state == S_DONE): dump_done = 1'b1;
         default: ;
      endcase
   end

   assign dump_busy = halt;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer: default and NUM_REGS=4
// instances share clock, reset and a model register bank.
module tb_reg_dump_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        dump_req, halt_ack, tx_ready;
   logic [31:0] reg_data;
   logic        halt, tx_valid, dump_busy, dump_done;
   logic [4:0]  reg_addr;
   logic [7:0]  tx_data;

   logic        dump_req_b, tx_ready_b;
   logic [31:0] reg_data_b;
   logic        halt_b, tx_valid_b, dump_busy_b, dump_done_b;
   logic [4:0]  reg_addr_b;
   logic [7:0]  tx_data_b;

   logic [31:0] regs [32];
   logic [7:0]  q [$];
   logic [7:0]  qb [$];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int xfer_b = 0;

   always #5 clock = ~clock;

   assign reg_data   = regs[reg_addr];
   assign reg_data_b = regs[reg_addr_b];

   reg_dump_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .dump_req  (dump_req),
      .halt_ack  (halt_ack),
      .reg_data  (reg_data),
      .tx_ready  (tx_ready),
      .halt      (halt),
      .reg_addr  (reg_addr),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .dump_busy (dump_busy),
      .dump_done (dump_done)
   );

   reg_dump_sequencer #(.NUM_REGS(4)) dut_b (
      .clock     (clock),
      .reset     (reset),
      .dump_req  (dump_req_b),
      .halt_ack  (halt_ack),
      .reg_data  (reg_data_b),
      .tx_ready  (tx_ready_b),
      .halt      (halt_b),
      .reg_addr  (reg_addr_b),
      .tx_data   (tx_data_b),
      .tx_valid  (tx_valid_b),
      .dump_busy (dump_busy_b),
      .dump_done (dump_done_b)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int n, input bit to_b);
      logic [31:0] w;
      if (to_b) qb.push_back(8'hA5);
      else q.push_back(8'hA5);
      for (int r = 0; r < n; r++) begin
         w = regs[r];
         for (int b = 3; b >= 0; b--) begin
            if (to_b) qb.push_back(w[8*b +: 8]);
            else q.push_back(w[8*b +: 8]);
         end
      end
   endtask

   always @(negedge clock) begin
      if (dump_done) done_cnt++;
      if (tx_valid) begin
         if (q.size() == 0) begin
            check("extra_byte", 32'(tx_valid), 32'd0);
         end else begin
            check("tx_data", 32'(tx_data), 32'(q[0]));
            if (tx_ready) void'(q.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (tx_valid_b) begin
         if (qb.size() == 0) begin
            check("b_extra_byte", 32'(tx_valid_b), 32'd0);
         end else begin
            check("b_tx_data", 32'(tx_data_b), 32'(qb[0]));
            if (tx_ready_b) begin
               void'(qb.pop_front());
               xfer_b++;
               check("b_addr_max", 32'(reg_addr_b <= 5'd3), 32'd1);
            end
         end
      end
   end

   // Called at #1 after an edge; returns cycles from accept edge to DONE.
   task automatic run_frame(input int rdy_mode, input int ack_delay,
                            input int req_at, output int done_at);
      push_frame(32, 1'b0);
      halt_ack = (ack_delay == 0);
      tx_ready = 1'b1;
      dump_req = 1'b1;
      @(posedge clock) #1;
      dump_req = 1'b0;
      check("busy_start", 32'(dump_busy), 32'd1);
      check("halt_start", 32'(halt), 32'd1);
      done_at = -1;
      for (int k = 0; k < 1000 && done_at < 0; k++) begin
         if (ack_delay > 0) begin
            if (k <= ack_delay) check("early_tx", 32'(tx_valid), 32'd0);
            if (k == ack_delay) halt_ack = 1'b1;
            if (k == ack_delay + 1) begin
               check("hdr_valid", 32'(tx_valid), 32'd1);
               check("hdr_data", 32'(tx_data), 32'hA5);
            end
         end
         if (k == req_at) dump_req = 1'b1;
         if (k == req_at + 1) dump_req = 1'b0;
         tx_ready = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
         if (dump_done) begin
            done_at = k;
            check("done_halt", 32'(halt), 32'd0);
            check("done_valid", 32'(tx_valid), 32'd0);
         end
         @(posedge clock) #1;
      end
      check("done_seen", 32'(done_at >= 0), 32'd1);
      check("q_empty", 32'(q.size()), 32'd0);
      check("idle_busy", 32'(dump_busy), 32'd0);
   endtask

   initial begin
      int d;
      int c0;
      for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
      dump_req   = 1'b0;
      dump_req_b = 1'b0;
      halt_ack   = 1'b1;
      tx_ready   = 1'b0;
      tx_ready_b = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_halt", 32'(halt), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_txdata", 32'(tx_data), 32'd0);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(dump_busy), 32'd0);
      check("rst_done", 32'(dump_done), 32'd0);
      reset = 1'b1;
      @(posedge clock) #1;

      run_frame(0, 0, -1, d);
      check("full_done_cycle", 32'(d), 32'd162);

      regs[5] = 32'hDEADBEEF;
      run_frame(1, 0, -1, d);
      regs[5] = 5 * 32'h01010101;

      run_frame(0, 10, -1, d);
      check("late_done_cycle", 32'(d), 32'd172);

      c0 = done_cnt;
      run_frame(0, 0, 50, d);
      check("req_mid_done_cycle", 32'(d), 32'd162);
      repeat (5) @(posedge clock);
      #1;
      check("req_mid_idle", 32'(dump_busy), 32'd0);
      check("req_mid_one_done", 32'(done_cnt - c0), 32'd1);

      // Reset lands during byte 2 of register 7.
      push_frame(32, 1'b0);
      tx_ready = 1'b1;
      dump_req = 1'b1;
      @(posedge clock) #1;
      dump_req = 1'b0;
      c0 = done_cnt;
      repeat (40) @(posedge clock);
      #1;
      check("mid_addr", 32'(reg_addr), 32'd7);
      check("mid_valid", 32'(tx_valid), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("arst_valid", 32'(tx_valid), 32'd0);
      check("arst_halt", 32'(halt), 32'd0);
      check("arst_addr", 32'(reg_addr), 32'd0);
      q.delete();
      #1 reset = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("post_rst_busy", 32'(dump_busy), 32'd0);
      check("post_rst_valid", 32'(tx_valid), 32'd0);
      check("post_rst_nodone", 32'(done_cnt - c0), 32'd0);

      push_frame(4, 1'b1);
      dump_req_b = 1'b1;
      @(posedge clock) #1;
      dump_req_b = 1'b0;
      d = -1;
      for (int k = 0; k < 300 && d < 0; k++) begin
         if (dump_done_b) d = k;
         @(posedge clock) #1;
      end
      check("b_done_cycle", 32'(d), 32'd22);
      check("b_bytes", 32'(xfer_b), 32'd17);
      check("b_q_empty", 32'(qb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
